round_judge: RTL and testbench

- Per-round referee for the factorization duel; produces the 3-bit round-outcome code consumed by the HP manager (000 none, 001 my win, 010 enemy win, 011 draw).
- Latches the problem word from the DB, accepts factor-pair submissions from both players, checks them, enforces a round timeout and emits a one-cycle outcome pulse.
- DB word layout: [35:34] level (consumed downstream, not used here), [33:16] reserved, [15:0] target product.

---
 rtl/judge_pkg.sv | 20 ++
 rtl/round_judge_factor_check.sv | 15 +
 rtl/round_judge.sv | 160 ++++++++++++++++
 tb/tb_round_judge.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/judge_pkg.sv
// Shared types and constants for the factorization-duel round referee.
package judge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam logic [2:0] HP_NONE   = 3'b000;
    localparam logic [2:0] HP_MY_WIN = 3'b001;
    localparam logic [2:0] HP_EN_WIN = 3'b010;
    localparam logic [2:0] HP_DRAW   = 3'b011;

    localparam int DB_LEVEL_MSB  = 35;
    localparam int DB_LEVEL_LSB  = 34;
    localparam int DB_TARGET_MSB = 15;
    localparam int DB_TARGET_LSB = 0;

endpackage

// File: rtl/round_judge_factor_check.sv
// Combinational check of one factor-pair submission against the round target.
module factor_check (
    input  logic [7:0]  i_f1,
    input  logic [7:0]  i_f2,
    input  logic [15:0] i_target,
    output logic        o_correct
);

    logic [15:0] w_prod;

    // Trivial factors (0 and 1) never count as a factorization.
    assign w_prod    = {8'd0, i_f1} * {8'd0, i_f2};
    assign o_correct = (i_f1 >= 8'd2) && (i_f2 >= 8'd2) && (w_prod == i_target);

endmodule

// File: rtl/round_judge.sv
// Per-round referee: latches the target, judges both players, times out, pulses the outcome.
// Optional wrong-answer lockout is enabled by defining ROUND_JUDGE_LOCKOUT_EN.
module round_judge
    import judge_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000,
    parameter int CNT_W       = 10,
    parameter int LOCK_CYC    = 50
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [35:0]      DB_IN,
    input  logic             MY_VALID,
    input  logic [7:0]       MY_F1,
    input  logic [7:0]       MY_F2,
    input  logic             EN_VALID,
    input  logic [7:0]       EN_F1,
    input  logic [7:0]       EN_F2,
    output logic [2:0]       HP_OUT,
    output logic             BUSY,
    output logic             MY_WRONG,
    output logic             EN_WRONG,
    output logic [CNT_W-1:0] TIME_LEFT
);

    state_t            r_state, w_state_nxt;
    logic [2:0]        w_hp_nxt;
    logic [15:0]       r_target;
    logic [CNT_W-1:0]  r_time_left;
    logic [2:0]        r_hp;
    logic              r_my_wrong, r_en_wrong;
    logic              w_my_ok, w_en_ok;
    logic              w_my_free, w_en_free;
    logic              w_my_act, w_en_act;
    logic              w_my_hit, w_en_hit;
    logic              w_in_wait, w_accept;
    logic              w_unused_db;

    assign w_unused_db = ^{DB_IN[DB_LEVEL_MSB:DB_LEVEL_LSB], DB_IN[DB_LEVEL_LSB-1:DB_TARGET_MSB+1]};

    factor_check u_my_check (
        .i_f1      (MY_F1),
        .i_f2      (MY_F2),
        .i_target  (r_target),
        .o_correct (w_my_ok)
    );

    factor_check u_en_check (
        .i_f1      (EN_F1),
        .i_f2      (EN_F2),
        .i_target  (r_target),
        .o_correct (w_en_ok)
    );

    assign w_in_wait = (r_state == WAIT);
    assign w_accept  = (r_state == IDLE) && START;
    assign w_my_act  = w_in_wait && MY_VALID && w_my_free;
    assign w_en_act  = w_in_wait && EN_VALID && w_en_free;
    assign w_my_hit  = w_my_act && w_my_ok;
    assign w_en_hit  = w_en_act && w_en_ok;

`ifdef ROUND_JUDGE_LOCKOUT_EN
    localparam int LOCK_W = $clog2(LOCK_CYC + 1);

    logic [LOCK_W-1:0] r_my_lock, r_en_lock;

    // A locked player's strobe is dropped before it reaches the checker.
    always_ff @(posedge CLK) begin
        if (RST || w_accept) begin
            r_my_lock <= '0;
            r_en_lock <= '0;
        end else if (w_in_wait) begin
            if (w_my_act && !w_my_ok)
                r_my_lock <= LOCK_W'(LOCK_CYC);
            else if (r_my_lock != '0)
                r_my_lock <= r_my_lock - 1'b1;
            if (w_en_act && !w_en_ok)
                r_en_lock <= LOCK_W'(LOCK_CYC);
            else if (r_en_lock != '0)
                r_en_lock <= r_en_lock - 1'b1;
        end
    end

    assign w_my_free = (r_my_lock == '0);
    assign w_en_free = (r_en_lock == '0);
`else
    logic w_unused_lock;
    assign w_unused_lock = (LOCK_CYC != 0);
    assign w_my_free     = 1'b1;
    assign w_en_free     = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (RST)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Correct answers outrank the timeout; a double hit is a draw.
    always_comb begin
        w_state_nxt = r_state;
        w_hp_nxt    = HP_NONE;
        case (r_state)
            IDLE: begin
                if (START)
                    w_state_nxt = WAIT;
            end
            WAIT: begin
                if (w_my_hit && w_en_hit) begin
                    w_state_nxt = REPORT;
                    w_hp_nxt    = HP_DRAW;
                end else if (w_my_hit) begin
                    w_state_nxt = REPORT;
                    w_hp_nxt    = HP_MY_WIN;
                end else if (w_en_hit) begin
                    w_state_nxt = REPORT;
                    w_hp_nxt    = HP_EN_WIN;
                end else if (r_time_left == CNT_W'(1)) begin
                    w_state_nxt = REPORT;
                    w_hp_nxt    = HP_DRAW;
                end
            end
            REPORT: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_target    <= '0;
            r_time_left <= '0;
            r_hp        <= HP_NONE;
            r_my_wrong  <= 1'b0;
            r_en_wrong  <= 1'b0;
        end else begin
            r_hp       <= w_hp_nxt;
            r_my_wrong <= w_my_act && !w_my_ok;
            r_en_wrong <= w_en_act && !w_en_ok;
            if (w_accept) begin
                r_target    <= DB_IN[DB_TARGET_MSB:DB_TARGET_LSB];
                r_time_left <= CNT_W'(TIMEOUT_CYC);
            end else if (w_in_wait) begin
                r_time_left <= (w_state_nxt == WAIT) ? r_time_left - 1'b1 : '0;
            end
        end
    end

    assign HP_OUT    = r_hp;
    assign BUSY      = (r_state == WAIT) || (r_state == REPORT);
    assign MY_WRONG  = r_my_wrong;
    assign EN_WRONG  = r_en_wrong;
    assign TIME_LEFT = r_time_left;

endmodule

// File: tb/tb_round_judge.sv
// Directed bench for round_judge with a 20-cycle round and 5-cycle lockout.
module tb_round_judge;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [35:0] DB_IN = '0;
    logic        MY_VALID = 1'b0;
    logic [7:0]  MY_F1 = '0;
    logic [7:0]  MY_F2 = '0;
    logic        EN_VALID = 1'b0;
    logic [7:0]  EN_F1 = '0;
    logic [7:0]  EN_F2 = '0;
    logic [2:0]  HP_OUT;
    logic        BUSY;
    logic        MY_WRONG;
    logic        EN_WRONG;
    logic [9:0]  TIME_LEFT;

    int checks = 0;
    int errors = 0;

    round_judge #(
        .TIMEOUT_CYC (20),
        .CNT_W       (10),
        .LOCK_CYC    (5)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .DB_IN     (DB_IN),
        .MY_VALID  (MY_VALID),
        .MY_F1     (MY_F1),
        .MY_F2     (MY_F2),
        .EN_VALID  (EN_VALID),
        .EN_F1     (EN_F1),
        .EN_F2     (EN_F2),
        .HP_OUT    (HP_OUT),
        .BUSY      (BUSY),
        .MY_WRONG  (MY_WRONG),
        .EN_WRONG  (EN_WRONG),
        .TIME_LEFT (TIME_LEFT)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_round(input logic [15:0] target);
        DB_IN = {2'b10, 18'h2A5A5, target};
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        tick();
        tick();
        checks++; if (HP_OUT !== 3'b000) begin errors++; $display("FAIL reset_hp got %b want 000", HP_OUT); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", BUSY); end
        checks++; if (MY_WRONG !== 1'b0 || EN_WRONG !== 1'b0) begin errors++; $display("FAIL reset_wrong got %b%b want 00", MY_WRONG, EN_WRONG); end
        checks++; if (TIME_LEFT !== 10'd0) begin errors++; $display("FAIL reset_time got %0d want 0", TIME_LEFT); end
        RST = 1'b0;
        tick();
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", BUSY); end
    endtask

    task automatic test_my_win();
        start_round(16'd143);
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL mywin_busy got %b want 1", BUSY); end
        checks++; if (TIME_LEFT !== 10'd20) begin errors++; $display("FAIL mywin_time0 got %0d want 20", TIME_LEFT); end
        repeat (4) tick();
        checks++; if (TIME_LEFT !== 10'd16) begin errors++; $display("FAIL mywin_time4 got %0d want 16", TIME_LEFT); end
        MY_VALID = 1'b1; MY_F1 = 8'd11; MY_F2 = 8'd13;
        tick();
        MY_VALID = 1'b0;
        checks++; if (HP_OUT !== 3'b001) begin errors++; $display("FAIL mywin_hp got %b want 001", HP_OUT); end
        checks++; if (MY_WRONG !== 1'b0) begin errors++; $display("FAIL mywin_wrong got %b want 0", MY_WRONG); end
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL mywin_report_busy got %b want 1", BUSY); end
        checks++; if (TIME_LEFT !== 10'd0) begin errors++; $display("FAIL mywin_report_time got %0d want 0", TIME_LEFT); end
        tick();
        checks++; if (HP_OUT !== 3'b000) begin errors++; $display("FAIL mywin_pulse got %b want 000", HP_OUT); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL mywin_idle got %b want 0", BUSY); end
    endtask

    task automatic test_wrong_then_enemy();
        start_round(16'd143);
        MY_VALID = 1'b1; MY_F1 = 8'd1; MY_F2 = 8'd143;
        tick();
        MY_VALID = 1'b0;
        checks++; if (MY_WRONG !== 1'b1) begin errors++; $display("FAIL trivial_wrong got %b want 1", MY_WRONG); end
        checks++; if (HP_OUT !== 3'b000) begin errors++; $display("FAIL trivial_hp got %b want 000", HP_OUT); end
        checks++; if (BUSY !== 1'b1 || TIME_LEFT !== 10'd19) begin errors++; $display("FAIL trivial_stay got busy %b time %0d want 1 19", BUSY, TIME_LEFT); end
        EN_VALID = 1'b1; EN_F1 = 8'd13; EN_F2 = 8'd11;
        tick();
        EN_VALID = 1'b0;
        checks++; if (HP_OUT !== 3'b010) begin errors++; $display("FAIL enwin_hp got %b want 010", HP_OUT); end
        checks++; if (MY_WRONG !== 1'b0 || EN_WRONG !== 1'b0) begin errors++; $display("FAIL enwin_wrong got %b%b want 00", MY_WRONG, EN_WRONG); end
        tick();
    endtask

    task automatic test_both_draw();
        start_round(16'd221);
        MY_VALID = 1'b1; MY_F1 = 8'd13; MY_F2 = 8'd17;
        EN_VALID = 1'b1; EN_F1 = 8'd13; EN_F2 = 8'd17;
        tick();
        MY_VALID = 1'b0; EN_VALID = 1'b0;
        checks++; if (HP_OUT !== 3'b011) begin errors++; $display("FAIL both_hp got %b want 011", HP_OUT); end
        checks++; if (MY_WRONG !== 1'b0 || EN_WRONG !== 1'b0) begin errors++; $display("FAIL both_wrong got %b%b want 00", MY_WRONG, EN_WRONG); end
        tick();
    endtask

    task automatic test_mixed();
        start_round(16'd221);
        MY_VALID = 1'b1; MY_F1 = 8'd17; MY_F2 = 8'd13;
        EN_VALID = 1'b1; EN_F1 = 8'd3;  EN_F2 = 8'd5;
        tick();
        MY_VALID = 1'b0; EN_VALID = 1'b0;
        checks++; if (HP_OUT !== 3'b001) begin errors++; $display("FAIL mixed_hp got %b want 001", HP_OUT); end
        checks++; if (EN_WRONG !== 1'b1 || MY_WRONG !== 1'b0) begin errors++; $display("FAIL mixed_wrong got my %b en %b want 0 1", MY_WRONG, EN_WRONG); end
        tick();
    endtask

    task automatic test_timeout();
        start_round(16'd0);
        for (int i = 20; i >= 1; i--) begin
            checks++; if (TIME_LEFT !== 10'(i)) begin errors++; $display("FAIL timeout_count got %0d want %0d", TIME_LEFT, i); end
            checks++; if (HP_OUT !== 3'b000) begin errors++; $display("FAIL timeout_early got %b want 000 at %0d", HP_OUT, i); end
            checks++; if (MY_WRONG !== (i == 17)) begin errors++; $display("FAIL timeout_zero_wrong got %b want %b at %0d", MY_WRONG, (i == 17), i); end
            if (i == 18) begin
                MY_VALID = 1'b1; MY_F1 = 8'd0; MY_F2 = 8'd5;
            end else begin
                MY_VALID = 1'b0;
            end
            tick();
        end
        MY_VALID = 1'b0;
        checks++; if (HP_OUT !== 3'b011) begin errors++; $display("FAIL timeout_hp got %b want 011", HP_OUT); end
        checks++; if (TIME_LEFT !== 10'd0) begin errors++; $display("FAIL timeout_time got %0d want 0", TIME_LEFT); end
        tick();
        checks++; if (BUSY !== 1'b0 || HP_OUT !== 3'b000) begin errors++; $display("FAIL timeout_idle got busy %b hp %b want 0 000", BUSY, HP_OUT); end
    endtask

    task automatic test_correct_beats_timeout();
        start_round(16'd143);
        repeat (19) tick();
        checks++; if (TIME_LEFT !== 10'd1) begin errors++; $display("FAIL last_time got %0d want 1", TIME_LEFT); end
        EN_VALID = 1'b1; EN_F1 = 8'd11; EN_F2 = 8'd13;
        tick();
        EN_VALID = 1'b0;
        checks++; if (HP_OUT !== 3'b010) begin errors++; $display("FAIL last_hp got %b want 010", HP_OUT); end
        tick();
    endtask

    task automatic test_reset_mid();
        start_round(16'd143);
        tick();
        tick();
        RST = 1'b1;
        MY_VALID = 1'b1; MY_F1 = 8'd11; MY_F2 = 8'd13;
        tick();
        MY_VALID = 1'b0;
        checks++; if (HP_OUT !== 3'b000 || BUSY !== 1'b0) begin errors++; $display("FAIL rstmid_out got hp %b busy %b want 000 0", HP_OUT, BUSY); end
        checks++; if (TIME_LEFT !== 10'd0 || MY_WRONG !== 1'b0) begin errors++; $display("FAIL rstmid_time got time %0d wrong %b want 0 0", TIME_LEFT, MY_WRONG); end
        RST = 1'b0;
        tick();
        checks++; if (HP_OUT !== 3'b000 || BUSY !== 1'b0) begin errors++; $display("FAIL rstmid_after got hp %b busy %b want 000 0", HP_OUT, BUSY); end
    endtask

    task automatic test_back_to_back();
        start_round(16'd143);
        tick();
        DB_IN = {2'b01, 18'h0, 16'd221};
        START = 1'b1;
        tick();
        START = 1'b0;
        checks++; if (TIME_LEFT !== 10'd18) begin errors++; $display("FAIL busystart_time got %0d want 18", TIME_LEFT); end
        MY_VALID = 1'b1; MY_F1 = 8'd13; MY_F2 = 8'd17;
        tick();
        checks++; if (MY_WRONG !== 1'b1 || HP_OUT !== 3'b000) begin errors++; $display("FAIL busystart_target got wrong %b hp %b want 1 000", MY_WRONG, HP_OUT); end
        MY_F1 = 8'd11; MY_F2 = 8'd13;
        tick();
        MY_VALID = 1'b0;
        checks++; if (HP_OUT !== 3'b001) begin errors++; $display("FAIL b2b_first_hp got %b want 001", HP_OUT); end
        DB_IN = {2'b11, 18'h0, 16'd221};
        START = 1'b1;
        tick();
        checks++; if (BUSY !== 1'b0 || TIME_LEFT !== 10'd0) begin errors++; $display("FAIL report_start got busy %b time %0d want 0 0", BUSY, TIME_LEFT); end
        tick();
        START = 1'b0;
        checks++; if (BUSY !== 1'b1 || TIME_LEFT !== 10'd20) begin errors++; $display("FAIL b2b_accept got busy %b time %0d want 1 20", BUSY, TIME_LEFT); end
        MY_VALID = 1'b1; MY_F1 = 8'd13; MY_F2 = 8'd17;
        tick();
        MY_VALID = 1'b0;
        checks++; if (HP_OUT !== 3'b001) begin errors++; $display("FAIL b2b_second_hp got %b want 001", HP_OUT); end
        tick();
    endtask

`ifdef ROUND_JUDGE_LOCKOUT_EN
    task automatic test_lockout();
        start_round(16'd143);
        MY_VALID = 1'b1; MY_F1 = 8'd2; MY_F2 = 8'd2;
        tick();
        MY_VALID = 1'b0;
        checks++; if (MY_WRONG !== 1'b1) begin errors++; $display("FAIL lock_first_wrong got %b want 1", MY_WRONG); end
        tick();
        tick();
        MY_VALID = 1'b1; MY_F1 = 8'd11; MY_F2 = 8'd13;
        tick();
        checks++; if (HP_OUT !== 3'b000 || BUSY !== 1'b1) begin errors++; $display("FAIL lock_ignored got hp %b busy %b want 000 1", HP_OUT, BUSY); end
        MY_F1 = 8'd5; MY_F2 = 8'd5;
        tick();
        MY_VALID = 1'b0;
        checks++; if (MY_WRONG !== 1'b0) begin errors++; $display("FAIL lock_no_pulse got %b want 0", MY_WRONG); end
        EN_VALID = 1'b1; EN_F1 = 8'd13; EN_F2 = 8'd11;
        tick();
        EN_VALID = 1'b0;
        checks++; if (HP_OUT !== 3'b010) begin errors++; $display("FAIL lock_en_hp got %b want 010", HP_OUT); end
        tick();
    endtask
`else
    task automatic test_lockout();
        start_round(16'd143);
        MY_VALID = 1'b1; MY_F1 = 8'd2; MY_F2 = 8'd2;
        tick();
        checks++; if (MY_WRONG !== 1'b1) begin errors++; $display("FAIL nolock_wrong got %b want 1", MY_WRONG); end
        MY_F1 = 8'd11; MY_F2 = 8'd13;
        tick();
        MY_VALID = 1'b0;
        checks++; if (HP_OUT !== 3'b001 || MY_WRONG !== 1'b0) begin errors++; $display("FAIL nolock_hp got hp %b wrong %b want 001 0", HP_OUT, MY_WRONG); end
        tick();
    endtask
`endif

    task automatic test_idle_valid();
        MY_VALID = 1'b1; MY_F1 = 8'd3; MY_F2 = 8'd3;
        EN_VALID = 1'b1; EN_F1 = 8'd0; EN_F2 = 8'd0;
        tick();
        MY_VALID = 1'b0; EN_VALID = 1'b0;
        checks++; if (MY_WRONG !== 1'b0 || EN_WRONG !== 1'b0 || HP_OUT !== 3'b000) begin errors++; $display("FAIL idle_valid got %b%b hp %b want 00 000", MY_WRONG, EN_WRONG, HP_OUT); end
    endtask

    initial begin
        test_reset();
        test_idle_valid();
        test_my_win();
        test_wrong_then_enemy();
        test_both_draw();
        test_mixed();
        test_timeout();
        test_correct_beats_timeout();
        test_reset_mid();
        test_back_to_back();
        test_lockout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
